// File: rtl/clkcfg_seq.sv
// Clock-configuration sequencer: applies a requested CLK register value to the
// clock generator, turning enables on first, waiting for settling, then switching CLKSEL.
module clkcfg_seq #(
  parameter int unsigned SETTLE_CYCLES = 1600000,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned CNT_W         = 21
) (
  input  logic       clock_160,
  input  logic       res,
  input  logic       req_valid,
  input  logic [7:0] req_cfg,
  output logic       req_ready,
  output logic [6:0] cfg,
  output logic       busy,
  output logic       done,
  output logic       reset_req
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q;
  logic [6:0]       cfg_q;
  logic [6:0]       tgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             rstreq_q;

  logic             accept_s;
  logic             same_s;
  logic             settle_s;
  logic [6:0]       union_s;

  // Accept decode and the intermediate "enables on, old CLKSEL kept" value.
  always_comb begin
    accept_s = req_valid & ready_q;
    same_s   = (req_cfg[6:0] == cfg_q);
    union_s  = {cfg_q[6:5] | req_cfg[6:5], req_cfg[4:3], cfg_q[2:0]};
    settle_s = (req_cfg[6] & ~cfg_q[6]) |
               (req_cfg[5] & ~cfg_q[5]) |
               (req_cfg[5] & (req_cfg[4:3] != cfg_q[4:3]));
  end

  // Sequencer state, shared down-counter and all registered outputs.
  always_ff @(posedge clock_160 or posedge res) begin
    if (res) begin
      state_q  <= S_IDLE;
      cfg_q    <= 7'h00;
      tgt_q    <= 7'h00;
      cnt_q    <= CNT_ZERO;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rstreq_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rstreq_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            if (req_cfg[7]) begin
              rstreq_q <= 1'b1;
            end else if (same_s) begin
              done_q <= 1'b1;
            end else begin
              cfg_q   <= union_s;
              tgt_q   <= req_cfg[6:0];
              cnt_q   <= settle_s ? SETTLE_LOAD : CNT_ZERO;
              state_q <= S_SETTLE;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (cnt_q == CNT_ZERO) begin
            cfg_q   <= tgt_q;
            cnt_q   <= HOLD_LOAD;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_HOLD: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= CNT_ZERO;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign cfg       = cfg_q;
  assign done      = done_q;
  assign reset_req = rstreq_q;

endmodule

// File: tb/tb_clkcfg_seq.sv
// Directed bench for clkcfg_seq with SETTLE_CYCLES=8, HOLD_CYCLES=2:
// a cycle-by-cycle vector table plus hand sequences for back-pressure and mid-run reset.
module tb_clkcfg_seq;

  logic       clk = 1'b0;
  logic       res;
  logic       req_valid;
  logic [7:0] req_cfg;
  logic       req_ready;
  logic [6:0] cfg;
  logic       busy;
  logic       done;
  logic       reset_req;

  int total = 0;
  int bad   = 0;

  clkcfg_seq #(.SETTLE_CYCLES(8), .HOLD_CYCLES(2), .CNT_W(4)) dut (
    .clock_160(clk),
    .res      (res),
    .req_valid(req_valid),
    .req_cfg  (req_cfg),
    .req_ready(req_ready),
    .cfg      (cfg),
    .busy     (busy),
    .done     (done),
    .reset_req(reset_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic       v;
    logic [7:0] c;
    logic [6:0] ecfg;
    logic       erdy;
    logic       edone;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rs, logic v, logic [7:0] c, logic [6:0] ecfg,
                              logic erdy, logic edone, logic err);
    vec_t r;
    r.rs = rs; r.v = v; r.c = c; r.ecfg = ecfg;
    r.erdy = erdy; r.edone = edone; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input logic rs, input logic v, input logic [7:0] c);
    @(negedge clk);
    res = rs; req_valid = v; req_cfg = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [6:0] ecfg, input logic erdy,
                         input logic edone, input logic err);
    chk({nm, ".cfg"},       {1'b0, cfg},  {1'b0, ecfg});
    chk({nm, ".ready"},     {7'd0, req_ready}, {7'd0, erdy});
    chk({nm, ".busy"},      {7'd0, busy}, {7'd0, ~erdy});
    chk({nm, ".done"},      {7'd0, done}, {7'd0, edone});
    chk({nm, ".reset_req"}, {7'd0, reset_req}, {7'd0, err});
  endtask

  initial begin
    int n;
    res = 1'b1; req_valid = 1'b0; req_cfg = 8'h00;

    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 1'b0));
    // 0x00 -> 0x6F: union 0x68, settle 8 edges, hold 2 edges
    vecs.push_back(mk(1'b0, 1'b1, 8'h6F, 7'h68, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h68, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h6F, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h6F, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h6F, 1'b1, 1'b1, 1'b0));
    // 0x6F -> 0x00: union 0x67, no settle
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 7'h67, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 1'b0));
    // equal request and reset request
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 7'h00, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h80, 7'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 1'b0));
    // CLKSEL-only change: cfg holds at accept, switches one edge later
    vecs.push_back(mk(1'b0, 1'b1, 8'h07, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h07, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h07, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h07, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h87, 7'h07, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h07, 7'h07, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 7'h07, 1'b1, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      tick(vecs[i].rs, vecs[i].v, vecs[i].c);
      chk_all($sformatf("vec%0d", i), vecs[i].ecfg, vecs[i].erdy, vecs[i].edone, vecs[i].err);
    end

    // Back-pressure: 0x2A held valid during the 0x6F sequence (from cfg 0x07)
    tick(1'b0, 1'b1, 8'h6F);
    chk_all("bp.accept", 7'h6F, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      tick(1'b0, 1'b1, 8'h2A);
      n++;
      if (!req_ready) begin
        chk("bp.cfg_busy", {1'b0, cfg}, 8'h6F);
        chk("bp.done_busy", {7'd0, done}, 8'h00);
      end
    end while (!req_ready && n < 20);
    chk("bp.cycles", n[7:0], 8'd10);
    chk_all("bp.end", 7'h6F, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 8'h2A);
    chk_all("bp.accept2", 7'h6F, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00);
    chk_all("bp.switch", 7'h2A, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00);
    chk_all("bp.hold", 7'h2A, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00);
    chk_all("bp.done", 7'h2A, 1'b1, 1'b1, 1'b0);

    // Mid-sequence reset at E4 of the 0x6F sequence
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    chk_all("rst.idle", 7'h00, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 8'h6F);
    chk_all("rst.E0", 7'h68, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    res = 1'b1;
    #1;
    chk_all("rst.async", 7'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_all("rst.held", 7'h00, 1'b1, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b0, 8'h00);
    chk_all("rst.release", 7'h00, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 8'h6F);
    chk_all("rst.reacc", 7'h68, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      tick(1'b0, 1'b0, 8'h00);
      n++;
    end while (!done && n < 20);
    chk("rst.cycles", n[7:0], 8'd10);
    chk_all("rst.done", 7'h6F, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkcfg_seq.md
CLKCFG_SEQ -- requirements
Module: clkcfg_seq

Interface
- REQ-001 SHALL have parameter SETTLE_CYCLES, default 1600000, meaning the oscillator/PLL settle wait in clock cycles (10 ms at 160 MHz); legal range 1 to 2^CNT_W-1.
- REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning the post-switch quiet time before completion; legal range 1 to 2^CNT_W-1.
- REQ-003 SHALL have parameter CNT_W, default 21, meaning the width of the shared down-counter.
- REQ-004 SHALL have port clock_160, input, 1 bit, the single clock; all logic is on its rising edge.
- REQ-005 SHALL have port res, input, 1 bit, the reset: asynchronous, active-high.
- REQ-006 SHALL have port req_valid, input, 1 bit, meaning a CLKSET request is pending.
- REQ-007 SHALL have port req_cfg, input, 8 bits, the requested CLK register value: [7] RESET, [6] PLLENA, [5] OSCENA, [4:3] OSCM, [2:0] CLKSEL.
- REQ-008 SHALL have port req_ready, output, 1 bit, high only in IDLE.
- REQ-009 SHALL have port cfg, output, 7 bits, the registered clock configuration driven to the clock generator's cfg input.
- REQ-010 SHALL have port busy, output, 1 bit, equal to not req_ready.
- REQ-011 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
- REQ-012 SHALL have port reset_req, output, 1 bit, a one-cycle chip-reset request pulse.

Function
- REQ-013 SHALL implement states IDLE, SETTLE, HOLD, with all outputs registered.
- REQ-014 Acceptance SHALL occur on the edge where req_valid and req_ready are both high; req_cfg SHALL be sampled and captured only at that edge, and requests while busy SHALL be ignored (the requester holds valid).
- REQ-015 Accepting a request with req_cfg[7]=1 SHALL leave cfg unchanged, pulse reset_req in the following cycle, stay in IDLE, and produce no done.
- REQ-016 Accepting a request with req_cfg[7]=0 and req_cfg[6:0] equal to cfg SHALL pulse done in the following cycle and stay in IDLE.
- REQ-017 Otherwise, at the accept edge, cfg SHALL load the union value: [6:5] = old[6:5] OR new[6:5], [4:3] = new[4:3], [2:0] = old[2:0]; the state SHALL go to SETTLE.
- REQ-018 The settle requirement SHALL be true iff (new[6] and not old[6]) or (new[5] and not old[5]) or (new[5] and new[4:3] differ from old[4:3]).
- REQ-019 At the accept edge the counter SHALL load SETTLE_CYCLES-1 if settle is required, else 0.
- REQ-020 In SETTLE, the counter SHALL decrement each edge; on the edge where it reads 0, cfg SHALL load new[6:0], the counter SHALL load HOLD_CYCLES-1, and the state SHALL go to HOLD.
- REQ-021 In HOLD, the counter SHALL decrement each edge; on the edge where it reads 0, the state SHALL go to IDLE and done SHALL pulse in the same cycle that req_ready rises.
- REQ-022 Consequently the new cfg SHALL appear SETTLE_CYCLES edges after accept (1 edge with no settle), and done SHALL appear HOLD_CYCLES edges after that.
- REQ-023 cfg SHALL change only at the accept edge and at the SETTLE exit edge; the CLKSEL field SHALL never change before the enables it needs are on.
- REQ-024 The counter SHALL never underflow or wrap; it SHALL only be loaded or decremented from a nonzero value.

Reset
- REQ-025 While res is high, and immediately on its assertion, the block SHALL force state=IDLE, cfg=7'h00 (RCFAST), counter=0, done=0, reset_req=0.
- REQ-026 res asserted mid-operation SHALL abort the sequence with no done pulse; req_ready SHALL be 1 on the first edge after release.

Verification (SETTLE_CYCLES=8, HOLD_CYCLES=2)
- REQ-027 Apply and release res -> cfg=0x00, req_ready=1, busy=0, done=0, reset_req=0.
- REQ-028 From cfg 0x00, request 0x6F -> cfg=0x68 after the accept edge E0, cfg=0x6F at E8, done pulse at E10, busy high E0..E9.
- REQ-029 From cfg 0x6F, request 0x00 -> cfg=0x67 at E0, cfg=0x00 at E1, done at E3.
- REQ-030 Request equal to the current cfg, and separately request 0x80 -> done (respectively reset_req) pulses one cycle after accept; cfg is unchanged in both cases.
- REQ-031 Hold req_valid with 0x2A during an active sequence -> it is not accepted until req_ready rises, then it is processed normally.
- REQ-032 Assert res at E4 of the 0x6F sequence -> cfg=0x00 immediately, no done, and the next request is accepted normally.
